mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS CPU.
- Sits beside the single-cycle ALU in the EX stage.
- Executes mult, multu, div, divu, mthi and mtlo.
- Asserts busy while an operation is in flight, so hazard control can stall HI/LO consumers (mfhi/mflo) and further MDU instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch request; MDUOp is sampled when start=1.
- MDUOp  input  3  operation select; encodings in the package.
- A  input  WIDTH  operand 1 (rs): multiplicand, dividend, or mthi/mtlo data.
- B  input  WIDTH  operand 2 (rt): multiplier or divisor.
- busy  output  1  operation in flight.
- HI  output  WIDTH  HI register (product high half, or remainder).
- LO  output  WIDTH  LO register (product low half, or quotient).

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: HI=0, LO=0, busy=0, counter=0, pending result discarded. This also applies when reset hits mid-operation.
- State machine, two states:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Launch (IDLE, start=1, MDUOp in {MULT, MULTU, DIV, DIVU}) at edge T:
  - Latch the full result into internal hold registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy is high in cycles T+1 through T+N.
- Completion: at the edge ending cycle T+N, HI/LO take the held result and the FSM returns to IDLE. New HI/LO and busy=0 are both visible in cycle T+N+1.
- HI/LO hold their old values throughout RUN.
- mthi/mtlo: start=1 with MTHI/MTLO in IDLE writes A into HI or LO at the next edge, with no busy cycles.
- Ignored requests:
  - start while busy=1 (any op) is ignored. The pipeline guarantees it never issues one; the bench checks it is ignored.
  - start with MDUOp=NONE or an undefined encoding is ignored.
- Multiply:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH product.
  - MULTU: unsigned product.
  - In both cases HI = product[2W-1:W], LO = product[W-1:0].
- Divide:
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - DIV: signed; quotient truncates toward zero, remainder takes the sign of the dividend.
  - Overflow case (-2^(W-1) / -1): LO = -2^(W-1), HI = 0.
- Divide by zero (B=0): the unit still runs DIV_CYCLES busy cycles, and HI/LO are left unchanged at completion.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Arithmetic: result may be computed combinationally at launch (one-shot) or iteratively. Only cycle-exact busy/HI/LO timing is architectural.

Decomposition:
- Package mdu_pkg holds:
  - MDUOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - FSM state typedef: IDLE, RUN.
- One natural sub-module: mdu_div, a signed/unsigned divider producing quotient/remainder with the zero and overflow rules above.
- Multiply is inline.

Test Plan:
1. MULT with A=-3 (0xFFFFFFFD), B=7 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0 in the same cycle.
2. MULTU with A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
3. DIV with A=-7, B=2 -> 10 busy cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with A=7, B=2 -> LO=3, HI=1.
4. DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then DIV with B=0 -> busy for 10 cycles, HI/LO unchanged.
5. MTHI with A=0x12345678 -> HI=0x12345678 next cycle, busy never asserts. MTLO or MULT issued while busy -> HI/LO and counter unaffected.
6. Reset asserted in the 3rd busy cycle of a DIV -> next cycle busy=0, HI=0, LO=0, and no late write-back afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// MDU shared definitions: operation encodings and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_div.sv
// Signed/unsigned divider: quotient truncates toward zero, remainder follows dividend sign.
// Latency: combinational.
// Backpressure: none; div_zero flags a zero divisor so the caller can suppress write-back.
module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes, then restore signs. The most negative dividend has a
    // magnitude that only fits as unsigned, which makes -2^(W-1)/-1 wrap back
    // to -2^(W-1) with a zero remainder without any special casing.
    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = (b == '0);
        // Keep the divider well-defined on a zero divisor; the result is discarded anyway.
        b_safe   = div_zero ? WIDTH'(1) : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem      = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO; result computed at launch, published after a fixed busy window.
// Latency: MULT_CYCLES busy cycles for mult/multu, DIV_CYCLES for div/divu, mthi/mtlo at the next edge.
// Backpressure: busy stalls consumers; any start while busy is ignored.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  res_hi_q, res_hi_d;
    logic [WIDTH-1:0]  res_lo_q, res_lo_d;
    logic              res_wr_q, res_wr_d;

    logic              is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  div_quot;
    logic [WIDTH-1:0]  div_rem;
    logic              div_zero;

    // Sign-extended operands multiplied modulo 2^(2W) give the signed product directly.
    always_comb begin
        is_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
        a_ext     = is_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_ext     = is_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod      = a_ext * b_ext;
    end

    mdu_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .a        (A),
        .b        (B),
        .is_signed(is_signed),
        .quot     (div_quot),
        .rem      (div_rem),
        .div_zero (div_zero)
    );

    // Next-state: launch captures the result into hold registers, RUN counts down and publishes on the last cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            res_hi_d = prod[2*WIDTH-1:WIDTH];
                            res_lo_d = prod[WIDTH-1:0];
                            res_wr_d = 1'b1;
                            cnt_d    = MULT_CNT;
                            state_d  = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_hi_d = div_rem;
                            res_lo_d = div_quot;
                            res_wr_d = ~div_zero;
                            cnt_d    = DIV_CNT;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset also drops any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner sequences, randomized ops vs. model.
// Latency: checks busy window length and HI/LO publish cycle for every operation.
// Backpressure: exercises starts issued while busy and a reset mid-divide.
module tb_mdu;

    localparam int W = 32;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_MULT  = 3'd1;
    localparam logic [2:0] T_MULTU = 3'd2;
    localparam logic [2:0] T_DIV   = 3'd3;
    localparam logic [2:0] T_DIVU  = 3'd4;
    localparam logic [2:0] T_MTHI  = 3'd5;
    localparam logic [2:0] T_MTLO  = 3'd6;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   MDUOp;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int total;
    int bad;

    // Reference architectural state.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    mdu #(
        .WIDTH(W),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .MDUOp(MDUOp),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int busy_cycles(input logic [2:0] op);
        case (op)
            T_MULT, T_MULTU: return 5;
            T_DIV, T_DIVU:   return 10;
            default:         return 0;
        endcase
    endfunction

    // Architectural result of one operation, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi_in, input logic [W-1:0] lo_in,
                         output logic [W-1:0] hi_out, output logic [W-1:0] lo_out);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi_out = hi_in;
        lo_out = lo_in;
        case (op)
            T_MULT: begin
                p = 64'(sa * sb);
                hi_out = p[63:32];
                lo_out = p[31:0];
            end
            T_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                hi_out = p[63:32];
                lo_out = p[31:0];
            end
            T_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                lo_out = q[31:0];
                hi_out = r[31:0];
            end
            T_DIVU: if (b != 0) begin
                lo_out = a / b;
                hi_out = a % b;
            end
            T_MTHI: hi_out = a;
            T_MTLO: lo_out = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle and check busy window, hold behaviour and final HI/LO.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int n;
        n = busy_cycles(op);
        start = 1'b1;
        MDUOp = op;
        A = a;
        B = b;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check({name, " busy"}, {31'd0, busy}, 32'd1);
            if (HI !== m_hi || LO !== m_lo) check({name, " hold"}, HI ^ LO, m_hi ^ m_lo);
            step();
        end
        check({name, " idle"}, {31'd0, busy}, 32'd0);
        check({name, " HI"}, HI, exp_hi);
        check({name, " LO"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        logic [W-1:0] eh, el;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        MDUOp = T_NONE;
        A = '0;
        B = '0;
        m_hi = '0;
        m_lo = '0;
        step();
        step();
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);

        vecs[0] = '{T_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{T_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{T_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{T_DIVU,  32'd7,         32'd2,        32'd1,         32'd3};
        vecs[4] = '{T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        vecs[5] = '{T_DIV,   32'd1234,      32'd0,        32'd0,         32'h8000_0000};
        vecs[6] = '{T_MTHI,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'h8000_0000};
        vecs[7] = '{T_MTLO,  32'h0000_ABCD, 32'd0,        32'h1234_5678, 32'h0000_ABCD};
        vecs[8] = '{T_NONE,  32'hDEAD_BEEF, 32'd1,        32'h1234_5678, 32'h0000_ABCD};
        vecs[9] = '{3'd7,    32'hDEAD_BEEF, 32'd1,        32'h1234_5678, 32'h0000_ABCD};

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Starts issued while busy must not disturb the running MULT or its timing.
        model(T_MULT, 32'd100, 32'hFFFF_FFFE, m_hi, m_lo, eh, el);
        start = 1'b1;
        MDUOp = T_MULT;
        A = 32'd100;
        B = 32'hFFFF_FFFE;
        step();
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("intrude busy c%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("intrude HI c%0d", i), HI, m_hi);
            check($sformatf("intrude LO c%0d", i), LO, m_lo);
            start = (i == 2) || (i == 3) || (i == 4);
            MDUOp = (i == 2) ? T_MTLO : (i == 3) ? T_MULT : T_MTHI;
            A = 32'hCAFE_0000 + 32'(i);
            B = 32'd5;
            step();
        end
        start = 1'b0;
        check("intrude idle", {31'd0, busy}, 32'd0);
        check("intrude HI", HI, eh);
        check("intrude LO", LO, el);
        m_hi = eh;
        m_lo = el;
        step();
        check("intrude settled", {31'd0, busy}, 32'd0);

        // Reset in the 3rd busy cycle of a DIV discards the pending result.
        start = 1'b1;
        MDUOp = T_DIV;
        A = 32'd100;
        B = 32'd7;
        step();
        start = 1'b0;
        step();
        step();
        check("rst pre busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst HI", HI, 32'd0);
        check("rst LO", LO, 32'd0);
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
                check($sformatf("rst late c%0d", i), HI | LO | {31'd0, busy}, 32'd0);
            step();
        end
        check("rst late HI", HI, 32'd0);
        check("rst late LO", LO, 32'd0);

        // Randomized ops against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 20)) - 32'd10;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, m_hi, m_lo, eh, el);
            run_op($sformatf("rand%0d op%0d", k, rop), rop, ra, rb, eh, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
